// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundles every bus between the ALU arbiter and its neighbours:
//   - the two request channels (packed per requester),
//   - the drive/capture bus to the shared combinational ALU,
//   - the single tagged response channel.
//
// Modports:
//   slave  : the arbiter itself (consumes requests, drives the ALU and responses)
//   master : the environment (requesters, ALU instance, response consumer)
//
// Signals (WIDTH = operand/result width):
//   req_valid [1:0]        per-requester request valid
//   req_ready [1:0]        per-requester accept, at most one bit high
//   req_a/req_b [2*WIDTH]  operand A/B, requester i at [i*WIDTH +: WIDTH]
//   req_sel   [3:0]        op select, requester i at [2i+1:2i]
//   alu_a/alu_b [WIDTH]    to ALU operands
//   alu_sel   [1:0]        to ALU op select
//   alu_out   [WIDTH]      from ALU result
//   alu_flags [3:0]        from ALU flags {N,Z,C,V}
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 requester that owns the response
//   rsp_data  [WIDTH]      captured ALU result
//   rsp_flags [3:0]        captured {N,Z,C,V}
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [2*WIDTH-1:0] req_a;
  logic [2*WIDTH-1:0] req_b;
  logic [3:0]         req_sel;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic [1:0]         alu_sel;
  logic [WIDTH-1:0]   alu_out;
  logic [3:0]         alu_flags;

  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic [3:0]         rsp_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_sel,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_flags,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_sel,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_flags,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester round-robin arbiter and sequencer for a single shared
// combinational ALU. A request is accepted in IDLE, its operands are held in
// registers that drive the ALU during EXEC, the ALU result and flags are
// captured at the end of EXEC, and the tagged response is presented in RESP
// until the consumer takes it. One operation is in flight at a time, so with
// rsp_ready tied high the arbiter sustains one operation every three cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        alu_arbiter_if.slave (request, ALU and response channels)
//   stats_clr  (ALU_ARB_STATS_EN only) synchronous clear of grant counters
//   grant_cnt0 (ALU_ARB_STATS_EN only) saturating accept count, requester 0
//   grant_cnt1 (ALU_ARB_STATS_EN only) saturating accept count, requester 1
//
// Build option:
//   ALU_ARB_STATS_EN  when defined, adds the CNT_W parameter, the stats_clr
//                     input and the two saturating grant counters.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 32
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
  ,
  input  logic               stats_clr,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q,      state_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_id_q,     gnt_id_d;
  logic [WIDTH-1:0]   op_a_q,       op_a_d;
  logic [WIDTH-1:0]   op_b_q,       op_b_d;
  logic [1:0]         op_sel_q,     op_sel_d;
  logic               rsp_valid_q,  rsp_valid_d;
  logic               rsp_id_q,     rsp_id_d;
  logic [WIDTH-1:0]   rsp_data_q,   rsp_data_d;
  logic [3:0]         rsp_flags_q,  rsp_flags_d;

  logic               pick;
  logic [1:0]         req_ready_c;
  logic               accept;

  // -------------------------------------------------------------------------
  // Grant selection. When both requesters are valid the one that did not win
  // last time gets the slot; last_grant resets to 1 so requester 0 wins first.
  // req_ready is gated by rst_n so it reads 0 the instant reset asserts.
  // -------------------------------------------------------------------------
  always_comb begin
    pick        = 1'b0;
    req_ready_c = 2'b00;
    if (bus.req_valid == 2'b11) begin
      pick = ~last_grant_q;
    end else if (bus.req_valid == 2'b10) begin
      pick = 1'b1;
    end
    if ((state_q == IDLE) && rst_n && (bus.req_valid != 2'b00)) begin
      req_ready_c = pick ? 2'b10 : 2'b01;
    end
  end

  // A visible ready bit always coincides with the matching valid bit.
  assign accept = (req_ready_c != 2'b00);

  // -------------------------------------------------------------------------
  // Next-state and datapath updates.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d       = pick ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
          op_b_d       = pick ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
          op_sel_d     = pick ? bus.req_sel[3:2]           : bus.req_sel[1:0];
          gnt_id_d     = pick;
          last_grant_d = pick;
          state_d      = EXEC;
        end
      end
      // The operand registers have been driving the ALU for the whole cycle,
      // so its combinational result is settled by the closing edge.
      EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_flags_d = bus.alu_flags;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. Operand and response registers also reset so that the
  // ALU drive and response outputs return to 0 immediately on reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_id_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= 4'b0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.alu_a     = op_a_q;
  assign bus.alu_b     = op_b_q;
  assign bus.alu_sel   = op_sel_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_flags = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
  // -------------------------------------------------------------------------
  // Grant statistics: saturating per-requester accept counters. A clear in
  // the same cycle as an accept wins, leaving the counter at zero.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (accept) begin
      if (!pick && (cnt0_q != {CNT_W{1'b1}})) begin
        cnt0_d = cnt0_q + 1'b1;
      end
      if (pick && (cnt1_q != {CNT_W{1'b1}})) begin
        cnt1_d = cnt1_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`else
  // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Directed bench for alu_arbiter. Provides a behavioural stand-in for the
// shared ALU (add/sub/and/or with {N,Z,C,V}, C = carry out of a + ~b + 1 for
// subtract) and walks through single-requester operations, round-robin
// fairness, response back-pressure, reset during EXEC and, when
// ALU_ARB_STATS_EN is defined, the saturating grant counters.
// Inputs change and outputs are sampled around the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 32;
`ifdef ALU_ARB_STATS_EN
  localparam int CNT_W = 2;
`endif

  logic clk;
  logic rst_n;

  logic [WIDTH-1:0] a0, a1, b0, b1;
  logic [1:0]       sel0, sel1;

  int checks;
  int errors;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  assign bus.req_a   = {a1, a0};
  assign bus.req_b   = {b1, b0};
  assign bus.req_sel = {sel1, sel0};

`ifdef ALU_ARB_STATS_EN
  logic             stats_clr;
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;

  alu_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .stats_clr  (stats_clr),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );
`else
  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
`endif

  // Behavioural shared ALU.
  logic [WIDTH:0] alu_sum;
  always_comb begin
    alu_sum       = '0;
    bus.alu_out   = '0;
    bus.alu_flags = 4'b0000;
    unique case (bus.alu_sel)
      2'b00: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_out      = alu_sum[WIDTH-1:0];
        bus.alu_flags[1] = alu_sum[WIDTH];
        bus.alu_flags[0] = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) &&
                           (alu_sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      2'b01: begin
        alu_sum          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 1'b1;
        bus.alu_out      = alu_sum[WIDTH-1:0];
        bus.alu_flags[1] = alu_sum[WIDTH];
        bus.alu_flags[0] = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) &&
                           (alu_sum[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      2'b10: bus.alu_out = bus.alu_a & bus.alu_b;
      default: bus.alu_out = bus.alu_a | bus.alu_b;
    endcase
    bus.alu_flags[3] = bus.alu_out[WIDTH-1];
    bus.alu_flags[2] = (bus.alu_out == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_gnt;
  int gnt_at [6];
  logic gnt_who [6];
  int n_acc;

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0; sel0 = 2'b00; sel1 = 2'b00;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif

    // Reset values (valid asserted to show req_ready is held low).
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("rst_rsp_data",  64'(bus.rsp_data),  64'h0);
    chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'h0);
    chk("rst_alu_a",     64'(bus.alu_a),     64'h0);
    chk("rst_alu_b",     64'(bus.alu_b),     64'h0);
    chk("rst_alu_sel",   64'(bus.alu_sel),   64'h0);
`ifdef ALU_ARB_STATS_EN
    chk("rst_cnt0", 64'(grant_cnt0), 64'h0);
    chk("rst_cnt1", 64'(grant_cnt1), 64'h0);
`endif
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    // Requester 0: 5 + 3.
    @(negedge clk);
    bus.req_valid = 2'b01; a0 = 32'd5; b0 = 32'd3; sel0 = 2'b00;
    #1 chk("t1_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    chk("t1_exec_ready", 64'(bus.req_ready), 64'h0);
    chk("t1_exec_alu_a", 64'(bus.alu_a), 64'd5);
    chk("t1_exec_alu_b", 64'(bus.alu_b), 64'd3);
    chk("t1_exec_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    @(negedge clk);
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t1_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("t1_rsp_data",  64'(bus.rsp_data),  64'd8);
    chk("t1_rsp_flags", 64'(bus.rsp_flags), 64'h0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t1_rsp_done", 64'(bus.rsp_valid), 64'h0);
    bus.rsp_ready = 1'b0;

    // Requester 1: 3 - 5.
    bus.req_valid = 2'b10; a1 = 32'd3; b1 = 32'd5; sel1 = 2'b01;
    #1 chk("t2_ready", 64'(bus.req_ready), 64'h2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t2_rsp_id",    64'(bus.rsp_id),    64'h1);
    chk("t2_rsp_data",  64'(bus.rsp_data),  64'hFFFF_FFFE);
    chk("t2_rsp_flags", 64'(bus.rsp_flags), 64'h8);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t2_rsp_done", 64'(bus.rsp_valid), 64'h0);

    // Fairness: both valid continuously, rsp_ready high.
    a0 = 32'd1; b0 = 32'd1; sel0 = 2'b00;
    a1 = 32'd2; b1 = 32'd2; sel1 = 2'b00;
    bus.req_valid = 2'b11;
    n_gnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (bus.req_ready != 2'b00) begin
        gnt_at[n_gnt]  = cyc;
        gnt_who[n_gnt] = bus.req_ready[1];
        n_gnt++;
      end
      if (n_gnt == 6) break;
      @(negedge clk);
    end
    chk("t3_grant_count", 64'(n_gnt), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_order_%0d", k), 64'(gnt_who[k]), 64'(k % 2));
      if (k > 0) chk($sformatf("t3_gap_%0d", k), 64'(gnt_at[k] - gnt_at[k-1]), 64'd3);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t3_drained", 64'(bus.rsp_valid), 64'h0);
    bus.rsp_ready = 1'b0;

    // Back-pressure: 0xF0F0 | 0x0F0F held for 5 cycles.
    bus.req_valid = 2'b01; a0 = 32'h0000_F0F0; b0 = 32'h0000_0F0F; sel0 = 2'b11;
    #1 chk("t4_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 2'b11;
    #1 chk("t4_exec_ready", 64'(bus.req_ready), 64'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_hold_valid_%0d", k), 64'(bus.rsp_valid), 64'h1);
      chk($sformatf("t4_hold_data_%0d", k),  64'(bus.rsp_data),  64'h0000_FFFF);
      chk($sformatf("t4_hold_ready_%0d", k), 64'(bus.req_ready), 64'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_released", 64'(bus.rsp_valid), 64'h0);
    #1 chk("t4_idle_ready", 64'(bus.req_ready), 64'h2);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;

    // Reset pulsed during EXEC.
    @(negedge clk);
    bus.req_valid = 2'b01; a0 = 32'h1234; b0 = 32'h1234; sel0 = 2'b10;
    #1 chk("t5_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1 chk("t5_exec_alu_a", 64'(bus.alu_a), 64'h1234);
    #2 rst_n = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    chk("t5_rst_alu_a",     64'(bus.alu_a),     64'h0);
    chk("t5_rst_alu_b",     64'(bus.alu_b),     64'h0);
    chk("t5_rst_alu_sel",   64'(bus.alu_sel),   64'h0);
    chk("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("t5_rst_req_ready", 64'(bus.req_ready), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5_no_rsp_%0d", k), 64'(bus.rsp_valid), 64'h0);
    end
    bus.req_valid = 2'b11; a0 = 32'h1234; b0 = 32'h00FF; sel0 = 2'b10;
    #1 chk("t5_prio0", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("t5_rsp_id",    64'(bus.rsp_id),    64'h0);
    chk("t5_rsp_data",  64'(bus.rsp_data),  64'h34);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("t5_rsp_done", 64'(bus.rsp_valid), 64'h0);
    bus.rsp_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
    // Saturation at 3 with CNT_W = 2, then clear racing a grant.
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("t6_cleared", 64'(grant_cnt0), 64'h0);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 2'b01;
    n_acc = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (bus.req_ready != 2'b00) n_acc++;
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    chk("t6_accepts", 64'(n_acc), 64'd4);
    chk("t6_cnt0_sat", 64'(grant_cnt0), 64'd3);
    chk("t6_cnt1", 64'(grant_cnt1), 64'd0);
    bus.req_valid = 2'b01;
    stats_clr = 1'b1;
    #1 chk("t6_clr_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    stats_clr = 1'b0;
    bus.req_valid = 2'b00;
    chk("t6_clr_wins", 64'(grant_cnt0), 64'd0);
    @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
